// File: rtl/conv_pkg.sv
// Shared state encoding and width helpers for the parameterised 2-D convolution pipeline.
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    COMPUTE = 2'd2,
    DRAIN   = 2'd3
  } state_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  // Sum of K*K full-precision products never overflows this width.
  function automatic int calc_ow(input int dw, input int k);
    return 2 * dw + clog2(k * k);
  endfunction

  function automatic int calc_out_w(input int ifm_w, input int k, input int stride);
    return (ifm_w - k) / stride + 1;
  endfunction

endpackage

// File: rtl/conv_mac_tree.sv
// K*K parallel multipliers (registered) followed by an adder tree (registered).
module conv_mac_tree
  import conv_pkg::*;
#(
  parameter int DW     = 16,
  parameter int K      = 3,
  parameter int SIGNED = 0,
  localparam int OW    = calc_ow(DW, K)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [K*K-1:0][DW-1:0] ifm_win,
  input  logic [K*K-1:0][DW-1:0] wt_win,
  output logic                   sum_valid,
  output logic                   pipe_busy,
  output logic [OW-1:0]          sum
);

  localparam int N  = K * K;
  localparam int PW = 2 * DW;

  logic [N-1:0][PW-1:0] prod_d, prod_q;
  logic [N-1:0][OW-1:0] prod_ext;
  logic [OW-1:0]        sum_d, sum_q;
  logic                 s1_valid_q, s2_valid_q;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_lane
      logic [PW-1:0] a_ext, b_ext;
      if (SIGNED != 0) begin : g_signed
        assign a_ext        = {{DW{ifm_win[gi][DW-1]}}, ifm_win[gi]};
        assign b_ext        = {{DW{wt_win[gi][DW-1]}}, wt_win[gi]};
        assign prod_ext[gi] = OW'({{OW{prod_q[gi][PW-1]}}, prod_q[gi]});
      end else begin : g_unsigned
        assign a_ext        = {{DW{1'b0}}, ifm_win[gi]};
        assign b_ext        = {{DW{1'b0}}, wt_win[gi]};
        assign prod_ext[gi] = OW'(prod_q[gi]);
      end
      // Low 2*DW bits of the extended product are exact in both modes.
      assign prod_d[gi] = a_ext * b_ext;
    end
  endgenerate

  always_comb begin
    sum_d = '0;
    for (int i = 0; i < N; i++) sum_d = sum_d + prod_ext[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q     <= '0;
      s1_valid_q <= 1'b0;
      sum_q      <= '0;
      s2_valid_q <= 1'b0;
    end else begin
      prod_q     <= prod_d;
      s1_valid_q <= in_valid;
      sum_q      <= sum_d;
      s2_valid_q <= s1_valid_q;
    end
  end

  assign sum       = sum_q;
  assign sum_valid = s2_valid_q;
  assign pipe_busy = s1_valid_q | s2_valid_q;

endmodule

// File: rtl/conv2d_param_pipe.sv
// Frame-buffered 2-D convolution: load IFM + kernel, then issue one window per cycle
// into a 3-stage multiply / add / output pipeline.
module conv2d_param_pipe
  import conv_pkg::*;
#(
  parameter int DW     = 16,
  parameter int IFM_W  = 7,
  parameter int K      = 3,
  parameter int STRIDE = 1,
  parameter int SIGNED = 0,
  localparam int OW    = calc_ow(DW, K)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic          weight_valid,
  input  logic [DW-1:0] In_IFM_1,
  input  logic [DW-1:0] In_Weight_1,
  output logic          out_valid,
  output logic [OW-1:0] Out_OFM,
  output logic          busy
);

  localparam int OUT_W  = calc_out_w(IFM_W, K, STRIDE);
  localparam int NPIX   = IFM_W * IFM_W;
  localparam int NWT    = K * K;
  localparam int PIX_AW = clog2(NPIX);
  localparam int WT_AW  = (NWT > 1) ? clog2(NWT) : 1;
  localparam int WT_CW  = clog2(NWT + 1);
  localparam int O_CW   = (OUT_W > 1) ? clog2(OUT_W) : 1;

  state_t              state_q, state_d;
  logic [PIX_AW-1:0]   pix_cnt_q, pix_cnt_d;
  logic [WT_CW-1:0]    wt_cnt_q, wt_cnt_d;
  logic [O_CW-1:0]     ox_q, ox_d, oy_q, oy_d;
  logic                busy_q, busy_d;
  logic                out_valid_q, out_valid_d;
  logic [OW-1:0]       ofm_q, ofm_d;

  logic                pix_we, wt_we, issue;
  logic [PIX_AW-1:0]   pix_widx;
  logic [WT_AW-1:0]    wt_widx;

  logic [DW-1:0]       ifm_buf_q [NPIX];
  logic [DW-1:0]       wt_buf_q  [NWT];
  logic [NWT-1:0][DW-1:0] ifm_win, wt_win;

  logic                sum_valid, pipe_busy;
  logic [OW-1:0]       sum;

  always_comb begin
    state_d   = state_q;
    pix_cnt_d = pix_cnt_q;
    wt_cnt_d  = wt_cnt_q;
    ox_d      = ox_q;
    oy_d      = oy_q;
    pix_we    = 1'b0;
    pix_widx  = pix_cnt_q;
    wt_we     = 1'b0;
    wt_widx   = WT_AW'(wt_cnt_q);
    issue     = 1'b0;
    case (state_q)
      IDLE: begin
        wt_cnt_d = '0;
        if (in_valid) begin
          pix_we    = 1'b1;
          pix_widx  = '0;
          pix_cnt_d = PIX_AW'(1);
          state_d   = LOAD;
          if (weight_valid) begin
            wt_we    = 1'b1;
            wt_widx  = '0;
            wt_cnt_d = WT_CW'(1);
          end
        end
      end
      LOAD: begin
        // Weights arrive on their own schedule; beats past K*K are dropped.
        if (weight_valid && (wt_cnt_q < WT_CW'(NWT))) begin
          wt_we    = 1'b1;
          wt_cnt_d = wt_cnt_q + WT_CW'(1);
        end
        if (in_valid) begin
          pix_we = 1'b1;
          if (pix_cnt_q == PIX_AW'(NPIX - 1)) begin
            state_d = COMPUTE;
            ox_d    = '0;
            oy_d    = '0;
          end else begin
            pix_cnt_d = pix_cnt_q + PIX_AW'(1);
          end
        end else begin
          state_d = IDLE;
        end
      end
      COMPUTE: begin
        issue = 1'b1;
        if (ox_q == O_CW'(OUT_W - 1)) begin
          ox_d = '0;
          if (oy_q == O_CW'(OUT_W - 1)) begin
            oy_d    = '0;
            state_d = DRAIN;
          end else begin
            oy_d = oy_q + O_CW'(1);
          end
        end else begin
          ox_d = ox_q + O_CW'(1);
        end
      end
      DRAIN: begin
        // Leave on the cycle the final result is on Out_OFM.
        if (!pipe_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ifm_win = '0;
    wt_win  = '0;
    if (issue) begin
      for (int ky = 0; ky < K; ky++) begin
        for (int kx = 0; kx < K; kx++) begin
          ifm_win[ky*K+kx] = ifm_buf_q[PIX_AW'((int'(oy_q) * STRIDE + ky) * IFM_W
                                               + int'(ox_q) * STRIDE + kx)];
          wt_win[ky*K+kx]  = wt_buf_q[ky*K+kx];
        end
      end
    end
  end

  always_comb begin
    busy_d      = (state_d != IDLE);
    out_valid_d = sum_valid;
    ofm_d       = sum_valid ? sum : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pix_cnt_q   <= '0;
      wt_cnt_q    <= '0;
      ox_q        <= '0;
      oy_q        <= '0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      ofm_q       <= '0;
    end else begin
      state_q     <= state_d;
      pix_cnt_q   <= pix_cnt_d;
      wt_cnt_q    <= wt_cnt_d;
      ox_q        <= ox_d;
      oy_q        <= oy_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      ofm_q       <= ofm_d;
    end
  end

  always_ff @(posedge clk) begin
    if (pix_we) ifm_buf_q[pix_widx] <= In_IFM_1;
    if (wt_we)  wt_buf_q[wt_widx]   <= In_Weight_1;
  end

  conv_mac_tree #(
    .DW     (DW),
    .K      (K),
    .SIGNED (SIGNED)
  ) u_mac (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (issue),
    .ifm_win   (ifm_win),
    .wt_win    (wt_win),
    .sum_valid (sum_valid),
    .pipe_busy (pipe_busy),
    .sum       (sum)
  );

  assign out_valid = out_valid_q;
  assign Out_OFM   = ofm_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_conv2d_param_pipe.sv
// Two instances (unsigned stride-1 DW=16, signed stride-2 DW=8) share one stimulus stream;
// expected results come from a direct arithmetic convolution model.
module tb_conv2d_param_pipe;

  localparam int W    = 7;
  localparam int KK   = 3;
  localparam int NPIX = W * W;
  localparam int NWT  = KK * KK;

  typedef struct {
    int     cyc;
    longint val;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, weight_valid;
  logic [15:0] in_ifm, in_wt;
  logic        ova, ovb, busy_a, busy_b;
  logic [35:0] ofm_a;
  logic [19:0] ofm_b;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  logic [15:0] fpix [NPIX];
  logic [15:0] fwt  [NWT];
  exp_t qa[$];
  exp_t qb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  conv2d_param_pipe u_dut_a (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .weight_valid (weight_valid),
    .In_IFM_1     (in_ifm),
    .In_Weight_1  (in_wt),
    .out_valid    (ova),
    .Out_OFM      (ofm_a),
    .busy         (busy_a)
  );

  conv2d_param_pipe #(
    .DW     (8),
    .IFM_W  (7),
    .K      (3),
    .STRIDE (2),
    .SIGNED (1)
  ) u_dut_b (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .weight_valid (weight_valid),
    .In_IFM_1     (in_ifm[7:0]),
    .In_Weight_1  (in_wt[7:0]),
    .out_valid    (ovb),
    .Out_OFM      (ofm_b),
    .busy         (busy_b)
  );

  function automatic longint elem(input logic [15:0] raw, input int dw, input bit sgn);
    longint v;
    v = longint'(raw) & ((longint'(1) << dw) - 1);
    if (sgn && v >= (longint'(1) << (dw - 1))) v = v - (longint'(1) << dw);
    return v;
  endfunction

  function automatic longint ref_out(input int stride, input int dw, input bit sgn,
                                     input int oy, input int ox);
    longint acc;
    acc = 0;
    for (int ky = 0; ky < KK; ky++)
      for (int kx = 0; kx < KK; kx++)
        acc += elem(fpix[(oy*stride+ky)*W + ox*stride + kx], dw, sgn)
             * elem(fwt[ky*KK+kx], dw, sgn);
    return acc;
  endfunction

  // Results of a frame whose last pixel was driven in cycle p appear from cycle p+4 on.
  task automatic push_expected(input int p);
    exp_t e;
    int   n;
    n = 0;
    for (int oy = 0; oy < 5; oy++)
      for (int ox = 0; ox < 5; ox++) begin
        e.cyc = p + 4 + n;
        e.val = ref_out(1, 16, 1'b0, oy, ox);
        qa.push_back(e);
        n++;
      end
    n = 0;
    for (int oy = 0; oy < 3; oy++)
      for (int ox = 0; ox < 3; ox++) begin
        e.cyc = p + 4 + n;
        e.val = ref_out(2, 8, 1'b1, oy, ox);
        qb.push_back(e);
        n++;
      end
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, got, want);
    end
  endtask

  task automatic drive_frame(input int drop_after, input int wt_off, output int last_cyc);
    int waited;
    int j;
    int extra;
    waited   = 0;
    j        = 0;
    extra    = 0;
    last_cyc = -1;
    // Garbage weights while busy must be ignored.
    while ((busy_a || busy_b) && waited < 400) begin
      weight_valid = 1'b1;
      in_wt        = 16'($urandom);
      @(posedge clk); #1;
      waited++;
    end
    checks++;
    if (busy_a || busy_b) begin
      errors++;
      $display("FAIL busy_wait: busy_a=%0b busy_b=%0b after %0d cycles, required 0", busy_a, busy_b, waited);
      weight_valid = 1'b0;
      return;
    end
    for (int i = 0; i < NPIX; i++) begin
      if (i == drop_after) begin
        in_valid     = 1'b0;
        weight_valid = 1'b0;
        return;
      end
      in_valid = 1'b1;
      in_ifm   = fpix[i];
      if (j < NWT && i >= wt_off && ((i - wt_off) % 2 == 0)) begin
        weight_valid = 1'b1;
        in_wt        = fwt[j];
        j++;
      end else if (j == NWT && extra < 2) begin
        weight_valid = 1'b1;
        in_wt        = 16'($urandom);
        extra++;
      end else begin
        weight_valid = 1'b0;
        in_wt        = 16'($urandom);
      end
      last_cyc = cyc;
      @(posedge clk); #1;
    end
    in_valid     = 1'b0;
    weight_valid = 1'b0;
    push_expected(last_cyc);
  endtask

  task automatic fill_random();
    for (int i = 0; i < NPIX; i++) fpix[i] = 16'($urandom);
    for (int i = 0; i < NWT; i++)  fwt[i]  = 16'($urandom);
  endtask

  exp_t ea, eb;
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (ova) begin
        if (qa.size() == 0) begin
          errors++;
          $display("FAIL dut_a_unexpected: out_valid at cycle %0d value %0d, required none", cyc, ofm_a);
        end else begin
          ea = qa.pop_front();
          if (ofm_a !== 36'(ea.val) || cyc != ea.cyc) begin
            errors++;
            $display("FAIL dut_a_result: got %0d at cycle %0d, required %0d at cycle %0d",
                     ofm_a, cyc, 36'(ea.val), ea.cyc);
          end else begin
            $display("dut_a out cycle %0d value %0d", cyc, ofm_a);
          end
        end
      end else if (ofm_a !== '0) begin
        errors++;
        $display("FAIL dut_a_idle_ofm: got %0d, required 0", ofm_a);
      end
      checks++;
      if (ovb) begin
        if (qb.size() == 0) begin
          errors++;
          $display("FAIL dut_b_unexpected: out_valid at cycle %0d value %0d, required none", cyc, $signed(ofm_b));
        end else begin
          eb = qb.pop_front();
          if (ofm_b !== 20'(eb.val) || cyc != eb.cyc) begin
            errors++;
            $display("FAIL dut_b_result: got %0d at cycle %0d, required %0d at cycle %0d",
                     $signed(ofm_b), cyc, eb.val, eb.cyc);
          end else begin
            $display("dut_b out cycle %0d value %0d", cyc, $signed(ofm_b));
          end
        end
      end else if (ofm_b !== '0) begin
        errors++;
        $display("FAIL dut_b_idle_ofm: got %0d, required 0", ofm_b);
      end
    end
  end

  initial begin
    int p;
    int t;
    rst_n        = 1'b0;
    in_valid     = 1'b0;
    weight_valid = 1'b0;
    in_ifm       = '0;
    in_wt        = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_out_valid_a", 64'(ova), 64'd0);
    chk("reset_ofm_a", 64'(ofm_a), 64'd0);
    chk("reset_busy_a", 64'(busy_a), 64'd0);
    chk("reset_out_valid_b", 64'(ovb), 64'd0);
    chk("reset_ofm_b", 64'(ofm_b), 64'd0);
    chk("reset_busy_b", 64'(busy_b), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Ramp pixels, unit weights.
    for (int i = 0; i < NPIX; i++) fpix[i] = 16'(i);
    for (int i = 0; i < NWT; i++)  fwt[i]  = 16'd1;
    drive_frame(-1, 0, p);
    $display("frame ramp last pixel cycle %0d", p);

    // Random frames, each started in the first IDLE cycle after the previous drain.
    for (int f = 0; f < 2; f++) begin
      fill_random();
      drive_frame(-1, int'($urandom_range(0, 3)), p);
      $display("frame random%0d last pixel cycle %0d", f, p);
    end

    // Extreme operands: signed instance sees -128 * 127.
    for (int i = 0; i < NPIX; i++) fpix[i] = 16'hFF80;
    for (int i = 0; i < NWT; i++)  fwt[i]  = 16'h007F;
    drive_frame(-1, 1, p);
    $display("frame extreme last pixel cycle %0d", p);

    // Abort after 20 pixels.
    fill_random();
    drive_frame(20, 1, p);
    @(negedge clk);
    chk("abort_busy_hold_a", 64'(busy_a), 64'd1);
    chk("abort_busy_hold_b", 64'(busy_b), 64'd1);
    @(posedge clk); #1;
    chk("abort_busy_fall_a", 64'(busy_a), 64'd0);
    chk("abort_busy_fall_b", 64'(busy_b), 64'd0);
    $display("frame abort after 20 pixels at cycle %0d", cyc);
    repeat (10) @(posedge clk);
    #1;

    // Reset in the middle of COMPUTE while results are streaming.
    fill_random();
    drive_frame(-1, 2, p);
    while (cyc < p + 10) begin
      @(posedge clk); #1;
    end
    chk("pre_reset_pending_a", 64'(qa.size()), 64'd19);
    chk("pre_reset_pending_b", 64'(qb.size()), 64'd3);
    rst_n = 1'b0;
    #1;
    chk("midreset_out_valid_a", 64'(ova), 64'd0);
    chk("midreset_ofm_a", 64'(ofm_a), 64'd0);
    chk("midreset_out_valid_b", 64'(ovb), 64'd0);
    chk("midreset_ofm_b", 64'(ofm_b), 64'd0);
    chk("midreset_busy_a", 64'(busy_a), 64'd0);
    qa.delete();
    qb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    $display("reset pulse mid-compute released at cycle %0d", cyc);
    repeat (5) @(posedge clk);
    #1;

    for (int f = 0; f < 3; f++) begin
      fill_random();
      drive_frame(-1, int'($urandom_range(0, 3)), p);
      $display("frame post_reset%0d last pixel cycle %0d", f, p);
    end

    t = 0;
    while ((qa.size() != 0 || qb.size() != 0) && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    chk("all_results_delivered", 64'(qa.size() + qb.size()), 64'd0);
    repeat (5) @(posedge clk);
    #1;
    chk("final_busy_a", 64'(busy_a), 64'd0);
    chk("final_busy_b", 64'(busy_b), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
